// File: rtl/nr_divider_seq.sv
// nr_divider_seq: handshaked signed fixed-point divider, Q = N / D, using a
// Newton-Raphson reciprocal of the normalised divisor.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready operand handshake; N_in, D_in signed Q(WIDTH-IN_F).IN_F
//   out_valid/out_ready result handshake; out signed Q(WIDTH-OUT_F).OUT_F
//   div_by_zero       out is the divide-by-zero saturation value
//   overflow          true quotient was outside the output range, saturated
//
// Flow: IDLE -> NORM -> SEED -> ITER (x ITER) -> SCALE -> DONE, or
// IDLE -> NORM -> SEED -> DONE when the divisor is zero.
module nr_divider_seq #(
    parameter int WIDTH = 32,
    parameter int IN_F  = 16,
    parameter int OUT_F = 28,
    parameter int ITER  = 4,
    parameter int GUARD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] N_in,
    input  logic [WIDTH-1:0] D_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             div_by_zero,
    output logic             overflow
);

    // Operand magnitudes carry one extra bit so -2^(WIDTH-1) is exact.
    localparam int AW  = WIDTH + 1;
    // Reciprocal X is unsigned Q2.FX.
    localparam int FX  = WIDTH + GUARD;
    localparam int XW  = FX + 2;
    localparam int PW  = AW + XW;
    localparam int XEW = 2 * XW + 2;
    localparam int LZW = $clog2(AW + 1);

    // Right shift applied to |N|*X, minus one so the first dropped bit is
    // kept for rounding. Dn is |D|<<lz read as a fraction with AW bits, so
    // the shift undoes the normalisation, drops X's fraction and re-scales
    // from IN_F to OUT_F. IN_F cancels because N and D share a format.
    localparam int R0 = AW + GUARD + (WIDTH - IN_F) + (IN_F - OUT_F) - 1;

    localparam logic [XW-1:0] ONE = XW'(1) << FX;
    // Seed X0 = 48/17 - 32/17 * Dn, minimax-optimal over Dn in [0.5, 1).
    localparam logic [XW-1:0] C48 = XW'((64'd48 << FX) / 64'd17);
    localparam logic [XW-1:0] C32 = XW'((64'd32 << FX) / 64'd17);

    localparam logic [WIDTH-1:0] MAX_Q = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_Q = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NORM  = 3'd1;
    localparam logic [2:0] S_SEED  = 3'd2;
    localparam logic [2:0] S_ITER  = 3'd3;
    localparam logic [2:0] S_SCALE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]     state;
    logic [AW-1:0]  absn_q, absd_q, dn_q;
    logic           sign_q, nneg_q, dz_q;
    logic [LZW-1:0] lz_q;
    logic [XW-1:0]  x_q;
    logic [2:0]     cnt_q;

    logic [AW-1:0]  absn_in, absd_in;
    logic [LZW-1:0] lz;
    logic [XW-1:0]  dx, x_next, x0;
    logic signed [XW:0]     e;
    logic signed [XEW-1:0]  xs, es;
    logic [PW-1:0]  p, t, mag, lim;
    logic [15:0]    sh;
    logic           ovf;
    logic [WIDTH-1:0] mv, q_res, dz_val;

    assign in_ready = (state == S_IDLE) && !rst;

    // Two's-complement magnitude in AW bits.
    assign absn_in = N_in[WIDTH-1] ? (~{N_in[WIDTH-1], N_in} + AW'(1)) : {1'b0, N_in};
    assign absd_in = D_in[WIDTH-1] ? (~{D_in[WIDTH-1], D_in} + AW'(1)) : {1'b0, D_in};

    // Leading-zero count: the highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < AW; i++)
            if (absd_q[i]) lz = LZW'(AW - 1 - i);
    end

    // Newton-Raphson step X' = X + X*(1 - Dn*X). Dn*X stays below 4, so it
    // fits Q2.FX; the error term is signed and small.
    always_comb begin
        dx     = XW'((PW'(dn_q) * PW'(x_q)) >> AW);
        e      = $signed({1'b0, ONE}) - $signed({1'b0, dx});
        xs     = $signed({{(XW+1){1'b0}}, x_q});
        es     = {{(XW+1){e[XW]}}, e};
        x_next = x_q + XW'((xs * es) >>> FX);
        x0     = C48 - XW'((PW'(C32) * PW'(dn_q)) >> AW);
    end

    // Final scaling, round-to-nearest and saturation.
    always_comb begin
        p      = PW'(absn_q) * PW'(x_q);
        sh     = 16'(R0) - 16'(lz_q);
        t      = p >> sh;
        mag    = PW'(({1'b0, t} + (PW+1)'(1)) >> 1);
        // Negative results reach one further: -2^(WIDTH-1) is representable.
        lim    = (PW'(1) << (WIDTH-1)) - (sign_q ? PW'(0) : PW'(1));
        ovf    = mag > lim;
        mv     = ovf ? lim[WIDTH-1:0] : mag[WIDTH-1:0];
        q_res  = sign_q ? (WIDTH'(0) - mv) : mv;
        dz_val = (absn_q == '0) ? '0 : (nneg_q ? MIN_Q : MAX_Q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            absn_q      <= '0;
            absd_q      <= '0;
            dn_q        <= '0;
            sign_q      <= 1'b0;
            nneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            lz_q        <= '0;
            x_q         <= '0;
            cnt_q       <= '0;
            out         <= '0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        absn_q <= absn_in;
                        absd_q <= absd_in;
                        sign_q <= N_in[WIDTH-1] ^ D_in[WIDTH-1];
                        nneg_q <= N_in[WIDTH-1];
                        state  <= S_NORM;
                    end
                end
                S_NORM: begin
                    dz_q  <= (absd_q == '0);
                    lz_q  <= lz;
                    dn_q  <= absd_q << lz;
                    state <= S_SEED;
                end
                S_SEED: begin
                    // A zero divisor is resolved here rather than in NORM so
                    // its result appears a fixed two cycles after accept.
                    if (dz_q) begin
                        out         <= dz_val;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        x_q   <= x0;
                        cnt_q <= '0;
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    x_q   <= x_next;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'(ITER - 1)) state <= S_SCALE;
                end
                S_SCALE: begin
                    out         <= q_res;
                    overflow    <= ovf;
                    div_by_zero <= 1'b0;
                    out_valid   <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nr_divider_seq.sv
// Self-checking bench for nr_divider_seq with default parameters.
// Reference: exact rational quotient N*2^OUT_F/D in 64-bit integers.
module tb_nr_divider_seq;

    localparam int WIDTH = 32;
    localparam int OUT_F = 28;
    localparam int LAT   = 7;   // ITER + 3
    localparam int LAT0  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] N_in, D_in;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out;
    logic             div_by_zero, overflow;

    int total = 0;
    int bad   = 0;

    nr_divider_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .N_in(N_in), .D_in(D_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic [31:0] obs, input longint exp, input longint tol);
        longint d;
        d = longint'($signed(obs)) - exp;
        total++;
        assert (!$isunknown(obs) && d <= tol && d >= -tol) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h (+-%0d)", tag, obs, 32'(exp), tol);
        end
    endtask

    // cls: 0 in range (+-2), 1 saturated, 2 too close to the limit to call,
    // 3 divide-by-zero (exact).
    function automatic void model(input logic [31:0] n, input logic [31:0] d,
                                  output longint qe, output logic dze, output int cls);
        longint ln, ld, mx, mn;
        ln = longint'($signed(n));
        ld = longint'($signed(d));
        mx = (longint'(1) <<< 31) - 1;
        mn = -(longint'(1) <<< 31);
        if (d == 0) begin
            dze = 1'b1;
            cls = 3;
            qe  = (n == 0) ? 0 : (ln < 0 ? mn : mx);
        end else begin
            dze = 1'b0;
            qe  = (ln <<< OUT_F) / ld;
            if (qe > mx + 3)                        begin cls = 1; qe = mx; end
            else if (qe < mn - 3)                   begin cls = 1; qe = mn; end
            else if (qe <= mx - 3 && qe >= mn + 3)  cls = 0;
            else                                    cls = 2;
        end
    endfunction

    task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                          output logic [31:0] q, output logic dzf, output logic ovf, output int lat);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
        N_in = n; D_in = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        q = out; dzf = div_by_zero; ovf = overflow;
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic verify(input string tag, input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q;
        logic dzf, ovf, dze;
        int lat, cls;
        longint qe;
        run_op(n, d, q, dzf, ovf, lat);
        model(n, d, qe, dze, cls);
        chk({tag, "/lat"}, 64'(lat), 64'(d == 0 ? LAT0 : LAT));
        chk({tag, "/dz"}, 64'(dzf), 64'(dze));
        case (cls)
            0: begin chk_tol({tag, "/q"}, q, qe, 2); chk({tag, "/ovf"}, 64'(ovf), 64'(0)); end
            1: begin chk_tol({tag, "/q"}, q, qe, 0); chk({tag, "/ovf"}, 64'(ovf), 64'(1)); end
            3: begin chk_tol({tag, "/q"}, q, qe, 0); chk({tag, "/ovf"}, 64'(ovf), 64'(0)); end
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] q0, n, d;
        int lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; N_in = '0; D_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/out", 64'(out), 64'(0));
        chk("rst/out_valid", 64'(out_valid), 64'(0));
        chk("rst/flags", 64'({div_by_zero, overflow}), 64'(0));
        chk("rst/in_ready_held", 64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst/in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Directed: 1/3 and the signed 7.5/2.5 family.
        verify("one_third", 32'h0001_0000, 32'h0003_0000);
        verify("m7p5_2p5",  32'hFFF8_8000, 32'h0002_8000);
        verify("7p5_m2p5",  32'h0007_8000, 32'hFFFD_8000);
        verify("m7p5_m2p5", 32'hFFF8_8000, 32'hFFFD_8000);
        run_op(32'h0001_0000, 32'h0003_0000, q0, n[0], n[1], lat);
        chk_tol("one_third/const", q0, 64'h0555_5555, 2);
        run_op(32'hFFF8_8000, 32'h0002_8000, q0, n[0], n[1], lat);
        chk_tol("neg3/const", q0, -64'sh3000_0000, 2);

        // Divide by zero and extreme operands.
        verify("dz_pos",  32'h0001_0000, 32'h0);
        verify("dz_neg",  32'hFFFF_0000, 32'h0);
        verify("dz_zero", 32'h0,         32'h0);
        verify("min_n",   32'h8000_0000, 32'h7FFF_FFFF);
        verify("min_d",   32'h0001_0000, 32'h8000_0000);
        verify("n_zero",  32'h0,         32'hFFFD_8000);

        // Random operands over a wide spread of magnitudes.
        for (int i = 0; i < 40; i++) begin
            n = $urandom;
            if (i % 3 == 0) n = 32'($signed(n) >>> $urandom_range(0, 20));
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) d = -d;
            if (i % 10 == 9) d = '0;
            verify($sformatf("rnd%0d", i), n, d);
        end

        // Backpressure: result held, new operands ignored while busy.
        out_ready = 1'b0;
        N_in = 32'h0001_0000; D_in = 32'h0004_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("bp/lat", 64'(lat), 64'(LAT));
        q0 = out;
        chk_tol("bp/q", q0, 64'h0400_0000, 2);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin N_in = 32'h0005_0000; D_in = 32'h0001_0000; in_valid = 1'b1; end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("bp/hold%0d", k), {out_valid, in_ready, out}, {1'b1, 1'b0, q0});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp/release", {out_valid, in_ready}, 64'b01);
        chk("bp/out_kept", 64'(out), 64'(q0));

        // Overflow, leaving out and overflow set before the mid-flight reset.
        verify("ovf_pos", 32'h0064_0000, 32'h0001_0000);
        verify("ovf_neg", 32'hFF9C_0000, 32'h0001_0000);
        chk("ovf/flag_left", 64'(overflow), 64'(1));

        N_in = 32'h0001_0000; D_in = 32'h0003_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst/out_valid", 64'(out_valid), 64'(0));
        chk("midrst/out", 64'(out), 64'(0));
        chk("midrst/flags", 64'({div_by_zero, overflow}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst/in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        verify("after_rst", 32'h0001_0000, 32'h0003_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
